bbox_overlay: RTL and testbench

Post-processing stage that sits directly downstream of the `vp` video processing block, between `vp` and the HDMI output. It takes `vp`'s binary-mask video stream and computes the bounding box of foreground pixels over each frame. It then draws that box onto the following frame and exports the latched coordinates. The stream passes through with a fixed 2-cycle latency, and sync and enable signals are delayed to match.

---
 rtl/bbox_overlay.sv | 157 +++++++++++++++
 tb/tb_bbox_overlay.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bbox_overlay.sv
// bbox_overlay: per-frame foreground bounding box with outline overlay, 2-cycle stream latency.
// Optional centre crosshair is enabled by defining BBOX_CROSSHAIR_EN.
module bbox_overlay #(
  parameter int          H_BITS    = 11,
  parameter int          V_BITS    = 11,
  parameter logic [7:0]  THRESH    = 8'd128,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [23:0]       pixel_in,
  output logic              de_out,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic [23:0]       pixel_out,
  output logic              box_valid,
  output logic [H_BITS-1:0] box_x_min,
  output logic [H_BITS-1:0] box_x_max,
  output logic [V_BITS-1:0] box_y_min,
  output logic [V_BITS-1:0] box_y_max
);
  typedef enum logic {SKIP, RUN} state_t;
  state_t state_q, state_d;
  logic [H_BITS-1:0] x_q, x_d, x0_q, x0_d;
  logic [V_BITS-1:0] y_q, y_d, y0_q, y0_d;
  logic de0_q, hs0_q, vs0_q, rise0_q;
  logic [23:0] pix0_q;
  logic vs_rise, de_fall;
  logic [H_BITS-1:0] acc_x0_q, acc_x0_d, acc_x1_q, acc_x1_d, ax0_b, ax1_b;
  logic [V_BITS-1:0] acc_y0_q, acc_y0_d, acc_y1_q, acc_y1_d, ay0_b, ay1_b;
  logic hit_q, hit_d, hit_b, fg, latch;
  logic bv_q, bv_d;
  logic [H_BITS-1:0] bx0_q, bx0_d, bx1_q, bx1_d;
  logic [V_BITS-1:0] by0_q, by0_d, by1_q, by1_d;
  logic in_x, in_y, on_edge, on_cross;
  logic de_out_q, hs_out_q, vs_out_q;
  logic [23:0] pix_out_q, pix_out_d;
`ifdef BBOX_CROSSHAIR_EN
  logic [H_BITS-1:0] cx;
  logic [V_BITS-1:0] cy;
`endif

  // Stage 0: saturating column/row counters and the coordinates of the incoming pixel
  always_comb begin
    vs_rise = v_sync_in & ~vs0_q;
    de_fall = de0_q & ~de_in;
    x_d = de_in ? (&x_q ? x_q : x_q + H_BITS'(1)) : '0;
    y_d = vs_rise ? '0 : (de_fall && !(&y_q)) ? y_q + V_BITS'(1) : y_q;
    x0_d = x_q;
    y0_d = vs_rise ? '0 : y_q;
  end

  // Frame control: latch the finished frame's box on vsync, then restart accumulation
  always_comb begin
    fg = de0_q && (pix0_q[15:8] >= THRESH);
    latch = rise0_q && (state_q == RUN);
    state_d = rise0_q ? RUN : state_q;
    bv_d = latch ? hit_q : bv_q;
    bx0_d = (latch && hit_q) ? acc_x0_q : bx0_q;
    bx1_d = (latch && hit_q) ? acc_x1_q : bx1_q;
    by0_d = (latch && hit_q) ? acc_y0_q : by0_q;
    by1_d = (latch && hit_q) ? acc_y1_q : by1_q;
    ax0_b = rise0_q ? '1 : acc_x0_q;
    ax1_b = rise0_q ? '0 : acc_x1_q;
    ay0_b = rise0_q ? '1 : acc_y0_q;
    ay1_b = rise0_q ? '0 : acc_y1_q;
    hit_b = rise0_q ? 1'b0 : hit_q;
    acc_x0_d = (fg && x0_q < ax0_b) ? x0_q : ax0_b;
    acc_x1_d = (fg && x0_q > ax1_b) ? x0_q : ax1_b;
    acc_y0_d = (fg && y0_q < ay0_b) ? y0_q : ay0_b;
    acc_y1_d = (fg && y0_q > ay1_b) ? y0_q : ay1_b;
    hit_d = fg | hit_b;
  end

  // Stage 1: paint the latched box outline (and optional crosshair) over the stage-0 pixel
  always_comb begin
    in_x = (x0_q >= bx0_q) && (x0_q <= bx1_q);
    in_y = (y0_q >= by0_q) && (y0_q <= by1_q);
    on_edge = ((x0_q == bx0_q || x0_q == bx1_q) && in_y) || ((y0_q == by0_q || y0_q == by1_q) && in_x);
`ifdef BBOX_CROSSHAIR_EN
    cx = H_BITS'(({1'b0, bx0_q} + {1'b0, bx1_q}) >> 1);
    cy = V_BITS'(({1'b0, by0_q} + {1'b0, by1_q}) >> 1);
    on_cross = (x0_q == cx || y0_q == cy) && in_x && in_y;
`else
    on_cross = 1'b0;
`endif
    pix_out_d = (bv_q && de0_q && (on_edge || on_cross)) ? BOX_COLOR : pix0_q;
  end

  // All state: pipeline stages, counters, accumulators, frame FSM and latched box
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SKIP;
      x_q       <= '0;
      y_q       <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      de0_q     <= 1'b0;
      hs0_q     <= 1'b0;
      vs0_q     <= 1'b0;
      rise0_q   <= 1'b0;
      pix0_q    <= '0;
      acc_x0_q  <= '1;
      acc_x1_q  <= '0;
      acc_y0_q  <= '1;
      acc_y1_q  <= '0;
      hit_q     <= 1'b0;
      bv_q      <= 1'b0;
      bx0_q     <= '0;
      bx1_q     <= '0;
      by0_q     <= '0;
      by1_q     <= '0;
      de_out_q  <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      pix_out_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      de0_q     <= de_in;
      hs0_q     <= h_sync_in;
      vs0_q     <= v_sync_in;
      rise0_q   <= vs_rise;
      pix0_q    <= pixel_in;
      acc_x0_q  <= acc_x0_d;
      acc_x1_q  <= acc_x1_d;
      acc_y0_q  <= acc_y0_d;
      acc_y1_q  <= acc_y1_d;
      hit_q     <= hit_d;
      bv_q      <= bv_d;
      bx0_q     <= bx0_d;
      bx1_q     <= bx1_d;
      by0_q     <= by0_d;
      by1_q     <= by1_d;
      de_out_q  <= de0_q;
      hs_out_q  <= hs0_q;
      vs_out_q  <= vs0_q;
      pix_out_q <= pix_out_d;
    end
  end

  assign de_out     = de_out_q;
  assign h_sync_out = hs_out_q;
  assign v_sync_out = vs_out_q;
  assign pixel_out  = pix_out_q;
  assign box_valid  = bv_q;
  assign box_x_min  = bx0_q;
  assign box_x_max  = bx1_q;
  assign box_y_min  = by0_q;
  assign box_y_max  = by1_q;
endmodule

// File: tb/tb_bbox_overlay.sv
// tb_bbox_overlay: frame-level and randomized checks of bbox_overlay against a behavioural model.
module tb_bbox_overlay;
  localparam logic [23:0] RED = 24'hFF0000;
`ifdef BBOX_CROSSHAIR_EN
  localparam int BLOB_RED = 39;
`else
  localparam int BLOB_RED = 28;
`endif
  logic clk = 0, rst_n = 1, de_i = 0, hs_i = 0, vs_i = 0;
  logic [23:0] pix_i = 0;
  logic de_out, h_sync_out, v_sync_out, box_valid;
  logic [23:0] pixel_out;
  logic [10:0] box_x_min, box_x_max, box_y_min, box_y_max;
  typedef struct packed {
    logic de, hs, vs;
    logic [23:0] pix;
    logic bv;
    logic [10:0] x0, x1, y0, y1;
  } rec_t;
  rec_t exp_r, pend;
  int vec = 0, miss = 0, red_cnt = 0, nfail = 0;
  int col, row, ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
  bit pde, pvs, armed, hit, bv;

  always #5 clk = ~clk;

  bbox_overlay dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_i), .h_sync_in(hs_i), .v_sync_in(vs_i), .pixel_in(pix_i),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
    .box_valid(box_valid), .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max)
  );

  // Reference: each sampled pixel gets its (column,row) position, is painted from the box of
  // the previous frame, then feeds the current frame's extent; outputs appear two edges later.
  always @(posedge clk or negedge rst_n) begin
    bit r, drw;
    int xc, yc;
    if (!rst_n) begin
      col = 0; row = 0; pde = 0; pvs = 0; armed = 0; hit = 0; bv = 0;
      bx0 = 0; bx1 = 0; by0 = 0; by1 = 0;
      ax0 = 2047; ax1 = 0; ay0 = 2047; ay1 = 0;
      exp_r = '0; pend = '0;
    end else begin
      exp_r = pend;
      r = vs_i && !pvs;
      xc = col;
      yc = r ? 0 : row;
      drw = bv && de_i && (((xc == bx0 || xc == bx1) && yc >= by0 && yc <= by1) ||
                           ((yc == by0 || yc == by1) && xc >= bx0 && xc <= bx1));
`ifdef BBOX_CROSSHAIR_EN
      drw = drw || (bv && de_i && (xc == (bx0 + bx1) / 2 || yc == (by0 + by1) / 2) &&
                    xc >= bx0 && xc <= bx1 && yc >= by0 && yc <= by1);
`endif
      if (r) begin
        if (armed) begin
          bv = hit;
          if (hit) begin bx0 = ax0; bx1 = ax1; by0 = ay0; by1 = ay1; end
        end
        armed = 1; hit = 0; ax0 = 2047; ax1 = 0; ay0 = 2047; ay1 = 0;
      end
      if (de_i && pix_i[15:8] >= 8'd128) begin
        hit = 1;
        if (xc < ax0) ax0 = xc;
        if (xc > ax1) ax1 = xc;
        if (yc < ay0) ay0 = yc;
        if (yc > ay1) ay1 = yc;
      end
      row = r ? 0 : (pde && !de_i && row < 2047) ? row + 1 : row;
      col = de_i ? (col < 2047 ? col + 1 : 2047) : 0;
      pde = de_i; pvs = vs_i;
      pend = {de_i, hs_i, vs_i, drw ? RED : pix_i, bv, 11'(bx0), 11'(bx1), 11'(by0), 11'(by1)};
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    vec++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out, box_valid, box_x_min, box_x_max, box_y_min, box_y_max} !== exp_r) begin
      miss++;
      if (nfail < 20)
        $display("FAIL stream t=%0t actual=%h required=%h", $time,
                 {de_out, h_sync_out, v_sync_out, pixel_out, box_valid, box_x_min, box_x_max, box_y_min, box_y_max}, exp_r);
      nfail++;
    end
    if (de_out && pixel_out == RED) red_cnt++;
  end

  task automatic chk(input string n, input int a, input int e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] p);
    @(posedge clk);
    #1;
    de_i = de; hs_i = hs; vs_i = vs; pix_i = p;
  endtask

  function automatic logic [23:0] pat(input int m, input int c, input int r);
    return m == 1 ? ((c >= 10 && c <= 20 && r >= 5 && r <= 9) ? 24'hFFFFFF : 24'h0) :
           m == 2 ? 24'h007F00 :
           m == 3 ? ((c == 0 && r == 0) ? 24'h008000 : 24'h0) : 24'h0;
  endfunction

  task automatic frame(input int m, input int rr);
    red_cnt = 0;
    repeat (3) cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);
    for (int r = 0; r < 48; r++) begin
      if (r == rr) begin
        @(posedge clk);
        #1;
        rst_n = 0; de_i = 0; hs_i = 0; vs_i = 0; pix_i = 0;
        #1;
        chk("rst_pixel_out", int'(pixel_out), 0);
        chk("rst_de_out", int'(de_out), 0);
        chk("rst_box_valid", int'(box_valid), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
      end
      for (int c = 0; c < 64; c++) cyc(1, 0, 0, pat(m, c, r));
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    end
  endtask

  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_box_valid", int'(box_valid), 0);
    chk("reset_pixel_out", int'(pixel_out), 0);
    chk("reset_box_x_max", int'(box_x_max), 0);
    rst_n = 1;
    frame(1, -1);
    frame(1, -1);
    chk("blob_x_min", int'(box_x_min), 10);
    chk("blob_x_max", int'(box_x_max), 20);
    chk("blob_y_min", int'(box_y_min), 5);
    chk("blob_y_max", int'(box_y_max), 9);
    chk("blob_valid", int'(box_valid), 1);
    chk("blob_red_pixels", red_cnt, BLOB_RED);
    frame(0, -1);
    chk("pre_empty_valid", int'(box_valid), 1);
    frame(1, -1);
    chk("empty_valid", int'(box_valid), 0);
    chk("empty_x_min", int'(box_x_min), 10);
    chk("empty_y_max", int'(box_y_max), 9);
    chk("empty_red_pixels", red_cnt, 0);
    frame(2, -1);
    frame(2, -1);
    chk("g127_valid", int'(box_valid), 0);
    frame(3, -1);
    frame(0, -1);
    chk("g128_valid", int'(box_valid), 1);
    chk("g128_x_min", int'(box_x_min), 0);
    chk("g128_x_max", int'(box_x_max), 0);
    chk("g128_y_min", int'(box_y_min), 0);
    chk("g128_y_max", int'(box_y_max), 0);
    chk("g128_red_pixels", red_cnt, 1);
    frame(1, 20);
    chk("after_rst_valid", int'(box_valid), 0);
    frame(1, -1);
    chk("first_vs_valid", int'(box_valid), 0);
    frame(1, -1);
    chk("second_vs_valid", int'(box_valid), 1);
    chk("second_vs_x_max", int'(box_x_max), 20);
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0, 24'($urandom) & 24'hFF7FFF);
    chk("rand_bg_valid", int'(box_valid), 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 120) == 0, 24'($urandom));
    repeat (3) cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
